// File: rtl/rf_bank_arbiter.sv
// Banked register-file arbiter: splits two-operand read requests into per-bank FIFOs,
// issues one access per bank per cycle with CDB writebacks taking priority over reads.
module rf_bank_arbiter #(
  parameter  int NUM_OC     = 4,
  parameter  int NUM_BANK   = 4,
  parameter  int ROW_W      = 3,
  parameter  int DATA_W     = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int OC_W       = $clog2(NUM_OC),
  localparam int BANK_W     = $clog2(NUM_BANK),
  localparam int REG_W      = ROW_W + BANK_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [OC_W-1:0]            req_ocid,
  input  logic [1:0]                 req_mask,
  input  logic [REG_W-1:0]           req_reg_a,
  input  logic [REG_W-1:0]           req_reg_b,
  output logic                       req_ready,
  input  logic                       wr_en,
  input  logic [REG_W-1:0]           wr_reg,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [NUM_BANK-1:0]        rf_re,
  output logic [NUM_BANK-1:0]        rf_we,
  output logic [NUM_BANK*ROW_W-1:0]  rf_addr,
  output logic [DATA_W-1:0]          rf_wdata,
  input  logic [NUM_BANK*DATA_W-1:0] rf_rdata,
  output logic [NUM_BANK-1:0]        bk_vld,
  output logic [NUM_BANK*OC_W-1:0]   bk_ocid,
  output logic [NUM_BANK-1:0]        bk_slot,
  output logic [NUM_BANK*DATA_W-1:0] bk_data,
  output logic [NUM_BANK-1:0]        bk_bz
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [OC_W-1:0]  ocid;
    logic             slot;
  } ent_t;

  ent_t                    mem_q  [NUM_BANK][FIFO_DEPTH];
  ent_t                    mem_d  [NUM_BANK][FIFO_DEPTH];
  logic [PTR_W-1:0]        rptr_q [NUM_BANK];
  logic [PTR_W-1:0]        rptr_d [NUM_BANK];
  logic [PTR_W-1:0]        wptr_q [NUM_BANK];
  logic [PTR_W-1:0]        wptr_d [NUM_BANK];
  logic [CNT_W-1:0]        cnt_q  [NUM_BANK];
  logic [CNT_W-1:0]        cnt_d  [NUM_BANK];
  logic [NUM_BANK-1:0]     vld_q, vld_d;
  logic [NUM_BANK*OC_W-1:0] ocid_q, ocid_d;
  logic [NUM_BANK-1:0]     slot_q, slot_d;

  logic [BANK_W-1:0]       bank_a, bank_b, wr_bank;
  logic [ROW_W-1:0]        row_a, row_b, wr_row;
  logic [NUM_BANK-1:0]     a_hit, b_hit;
  logic                    accept;

  assign bank_a  = req_reg_a[BANK_W-1:0];
  assign bank_b  = req_reg_b[BANK_W-1:0];
  assign wr_bank = wr_reg[BANK_W-1:0];
  assign row_a   = req_reg_a[REG_W-1:BANK_W];
  assign row_b   = req_reg_b[REG_W-1:BANK_W];
  assign wr_row  = wr_reg[REG_W-1:BANK_W];
  assign accept  = req_valid && req_ready;

  // Admission sees only the current occupancy; a pop in this same cycle is not credited.
  always_comb begin
    logic [1:0] need;
    req_ready = 1'b1;
    a_hit     = '0;
    b_hit     = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      a_hit[b] = req_mask[0] && (bank_a == BANK_W'(b));
      b_hit[b] = req_mask[1] && (bank_b == BANK_W'(b));
      need     = {1'b0, a_hit[b]} + {1'b0, b_hit[b]};
      if (CNT_W'(need) > (CNT_W'(FIFO_DEPTH) - cnt_q[b]))
        req_ready = 1'b0;
    end
  end

  always_comb begin
    ent_t             head;
    logic             pop;
    logic [PTR_W-1:0] wp;
    logic [1:0]       pushes;
    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    ocid_d  = ocid_q;
    slot_d  = slot_q;
    vld_d   = '0;
    rf_re   = '0;
    rf_we   = '0;
    rf_addr = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      head     = mem_q[b][rptr_q[b]];
      rf_we[b] = wr_en && (wr_bank == BANK_W'(b));
      pop      = !rf_we[b] && (cnt_q[b] != '0);
      rf_re[b] = pop;
      rf_addr[b*ROW_W +: ROW_W] = rf_we[b] ? wr_row : head.row;
      vld_d[b] = pop;
      if (pop) begin
        ocid_d[b*OC_W +: OC_W] = head.ocid;
        slot_d[b]              = head.slot;
        rptr_d[b]              = rptr_q[b] + PTR_W'(1);
      end
      // Operand a is pushed ahead of b when both land in the same bank.
      wp     = wptr_q[b];
      pushes = 2'd0;
      if (accept && a_hit[b]) begin
        mem_d[b][wp] = '{row: row_a, ocid: req_ocid, slot: 1'b0};
        wp           = wp + PTR_W'(1);
        pushes       = pushes + 2'd1;
      end
      if (accept && b_hit[b]) begin
        mem_d[b][wp] = '{row: row_b, ocid: req_ocid, slot: 1'b1};
        wp           = wp + PTR_W'(1);
        pushes       = pushes + 2'd1;
      end
      wptr_d[b] = wp;
      cnt_d[b]  = cnt_q[b] + CNT_W'(pushes) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        rptr_q[b] <= '0;
        wptr_q[b] <= '0;
        cnt_q[b]  <= '0;
      end
      vld_q  <= '0;
      ocid_q <= '0;
      slot_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      ocid_q <= ocid_d;
      slot_q <= slot_d;
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANK; b++)
      bk_bz[b] = (cnt_q[b] != '0);
  end

  assign bk_vld   = vld_q;
  assign bk_ocid  = ocid_q;
  assign bk_slot  = slot_q;
  assign bk_data  = rf_rdata;
  assign rf_wdata = wr_data;

endmodule

// File: doc/rf_bank_arbiter.md
# rf_bank_arbiter

Parametrised register-file bank arbiter between the operand collector units and the banked register file. It is the generalised successor of the fixed 4-bank / 4-collector RF controller. It accepts two-operand read requests tagged with a collector id and splits them into per-bank request FIFOs. Each cycle it issues at most one access per bank, giving CDB writebacks priority over reads. Read data returns to the collectors with collector id and operand slot tags, one cycle after issue.

## Interface
- NUM_OC, 4, number of collector units; OC_W = clog2(NUM_OC)
- NUM_BANK, 4, number of RF banks, power of two ≥2; BANK_W = clog2(NUM_BANK)
- ROW_W, 3, row address width per bank; REG_W = ROW_W+BANK_W
- DATA_W, 32, operand width
- FIFO_DEPTH, 4, entries per bank FIFO, power of two ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ocid  in  OC_W  requesting collector
- req_mask  in  2  bit0 = operand a used, bit1 = operand b used
- req_reg_a, req_reg_b  in  REG_W  register numbers; bank = reg[BANK_W-1:0], row = reg[REG_W-1:BANK_W]
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- wr_en  in  1  CDB writeback
- wr_reg  in  REG_W  writeback register
- wr_data  in  DATA_W  writeback data
- rf_re  out  NUM_BANK  per-bank read strobe
- rf_we  out  NUM_BANK  per-bank write strobe (one-hot or zero)
- rf_addr  out  NUM_BANK*ROW_W  per-bank row
- rf_wdata  out  DATA_W  = wr_data
- rf_rdata  in  NUM_BANK*DATA_W  bank read data, valid the cycle after rf_re
- bk_vld  out  NUM_BANK  returned operand valid
- bk_ocid  out  NUM_BANK*OC_W  destination collector
- bk_slot  out  NUM_BANK  0 = operand a, 1 = operand b
- bk_data  out  NUM_BANK*DATA_W  = rf_rdata
- bk_bz  out  NUM_BANK  bank FIFO non-empty

## Operation
- Each bank has one FIFO of {row, ocid, slot} with FIFO_DEPTH entries, a read pointer, a write pointer, and a count of clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
- Admission is atomic:
  - req_ready=1 only if every bank targeted by the set bits of req_mask has enough free slots.
  - If a and b hit the same bank, that bank needs 2 free slots; otherwise each target needs 1.
  - Free slots come from the current count only; a same-cycle pop is not credited.
  - req_mask=00 is always ready and has no effect.
- Push order: when a and b share a bank, a is written first and b second, so the pointer advances by 2.
- Per bank, each cycle:
  - If wr_en targets this bank: rf_we=1, rf_addr=wr row, rf_re=0, and the FIFO holds.
  - Else if the FIFO is non-empty: rf_re=1, rf_addr=head row, and the head is popped.
  - Else the bank is idle.
- A pop registers {ocid, slot} into the return stage. bk_vld is rf_re delayed by one cycle.
- Read-after-write ordering is guaranteed by the scoreboard; the arbiter neither forwards nor checks hazards.
- Push and pop on the same bank in the same cycle: count changes by (pushes − pop).

## Timing
- Reset (asynchronous):
  - All FIFOs empty, pointers 0.
  - bk_vld=0, bk_ocid=0, bk_slot=0.
  - Combinational outputs follow: rf_re=0, rf_we=0 when wr_en=0, req_ready=1, bk_bz=0.
- Reset mid-operation discards all queued and in-flight reads; no bk_vld follows.
- req_ready, rf_re, rf_we, rf_addr and bk_bz are combinational from registered state and current inputs. bk_* outputs are registered.
- Latency, with no write contention:
  - Accept in cycle T.
  - Entry visible at T+1; rf_re in T+1.
  - bk_vld in T+2.
  - An empty FIFO is never bypassed.
- Each cycle of write preemption on a bank adds one cycle to that bank's queue.
- A full FIFO deasserts req_ready for any request touching that bank. req_valid must be held until accepted.

## Test plan
- Reset, then req a=r5 (bank1,row1) and b=r10 (bank2,row2), ocid=2 -> rf_re[1], rf_re[2] at T+1 with rows 1 and 2; bk_vld[1] with ocid 2/slot 0 and bk_vld[2] with ocid 2/slot 1 at T+2.
- Same bank: a=r1, b=r5, ocid=3 -> bank1 reads row0 at T+1 and row1 at T+2; bk_slot 0 then 1.
- Write priority: bank0 holding 2 queued reads, wr_en to r4 for 2 cycles -> rf_we[0] both cycles, rf_re[0]=0, reads issue in the next two cycles in order.
- Full: fill bank3 with 4 entries while wr_en holds bank3 -> req_ready=0 for a bank3 request, still 1 for a bank0-only request. A request needing 2 slots with 1 free is refused.
- Wrap: 12 single-operand requests streamed to bank2 with ocid cycling 0..3 -> 12 returns in order with correct ocid, no loss.
- Assert rst with 3 entries queued -> bk_vld=0 and bk_bz=0 immediately; no returns after release.
